stopwatch_ctrl: RTL and testbench

- Sequencing controller for the stopwatch's 4-digit seven-segment display path.
- Runs the MM:SS BCD time base and a run/pause/adjust FSM, and drives four BCD digits plus a per-digit blank mask into the display multiplexer.
- Sits between the clock-divider tick generators and debounced buttons on one side and the display driver on the other.

---
 rtl/stopwatch_pkg.sv | 33 +++
 rtl/bcd2_counter.sv | 56 +++++
 rtl/stopwatch_ctrl.sv | 177 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and constants for the stopwatch display path:
//                FSM state encodings, BCD digit width, seconds wrap value,
//                blank masks for the minutes/seconds digit pairs and a
//                binary-to-two-digit-BCD helper.
//  Revision    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

  // FSM states; the encoding is visible on the status LED port
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_ADJUST = 2'd3
  } state_t;

  localparam int         c_BCD_W     = 4;
  localparam logic [6:0] c_SEC_MAX   = 7'd59;

  // Blank mask bit i blanks led_i; led_0/led_1 are minutes, led_2/led_3 seconds
  localparam logic [3:0] c_BLANK_MIN = 4'b0011;
  localparam logic [3:0] c_BLANK_SEC = 4'b1100;

  // Binary 0..99 to packed {tens, ones} BCD
  function automatic logic [2*c_BCD_W-1:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2_counter
//  Description : Two-digit BCD counter. Increments on inc, returns to 00 after
//                reaching the wrap value and flags carry in that cycle. A
//                synchronous clear has priority over inc.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd2_counter
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic [6:0]         wrap,
  output logic [c_BCD_W-1:0] tens,
  output logic [c_BCD_W-1:0] ones,
  output logic               carry
);

  logic [c_BCD_W-1:0]   r_tens;
  logic [c_BCD_W-1:0]   r_ones;
  logic [2*c_BCD_W-1:0] w_wrap_bcd;
  logic                 w_at_wrap;

  // wrap is driven by constants, so this conversion folds away
  assign w_wrap_bcd = to_bcd(wrap);
  assign w_at_wrap  = ({r_tens, r_ones} == w_wrap_bcd);
  assign carry      = inc & w_at_wrap;
  assign tens       = r_tens;
  assign ones       = r_ones;

  // Digit registers: clear, wrap to 00, or BCD increment with ones->tens carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (clr) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (inc) begin
      if (w_at_wrap) begin
        r_tens <= '0;
        r_ones <= '0;
      end else if (r_ones == 4'd9) begin
        r_ones <= '0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : MM:SS stopwatch sequencer. Run/pause/adjust FSM, BCD time
//                base and blink/blank generation for a 4-digit display mux.
//                Optional lap hold is built when STOPWATCH_LAP_EN is defined;
//                otherwise btn_lap is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MINUTES = 59
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1hz,
  input  logic               tick_2hz,
  input  logic               btn_pause,
  input  logic               btn_reset,
  input  logic               btn_lap,
  input  logic               adj_en,
  input  logic               adj_sel,
  output logic [c_BCD_W-1:0] led_0,
  output logic [c_BCD_W-1:0] led_1,
  output logic [c_BCD_W-1:0] led_2,
  output logic [c_BCD_W-1:0] led_3,
  output logic [3:0]         blank,
  output logic [1:0]         state
);

  state_t r_state, w_state_next;
  logic   r_phase, w_phase_next;
  logic [3:0] r_blank, w_blank_next;

  logic w_clr, w_sec_inc, w_min_inc, w_adj_tick;
  logic w_sec_carry, w_min_carry;
  logic [c_BCD_W-1:0] w_min_t, w_min_o, w_sec_t, w_sec_o;

  bcd2_counter u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_sec_inc),
    .wrap  (c_SEC_MAX),
    .tens  (w_sec_t),
    .ones  (w_sec_o),
    .carry (w_sec_carry)
  );

  bcd2_counter u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_min_inc),
    .wrap  (7'(MAX_MINUTES)),
    .tens  (w_min_t),
    .ones  (w_min_o),
    .carry (w_min_carry)
  );

  // Next state, counter enables, blink phase and blank mask; priority is
  // btn_reset > adj_en > btn_pause > tick
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_clr        = 1'b0;
    w_sec_inc    = 1'b0;
    w_min_inc    = 1'b0;
    w_adj_tick   = 1'b0;
    w_blank_next = 4'b0000;

    if (btn_reset) begin
      w_clr        = 1'b1;
      w_phase_next = 1'b0;
      w_state_next = adj_en ? ST_ADJUST : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (adj_en)         w_state_next = ST_ADJUST;
          else if (btn_pause) w_state_next = ST_RUN;
        end
        ST_RUN: begin
          if (adj_en) begin
            w_state_next = ST_ADJUST;
          end else begin
            // A tick coinciding with pause still counts
            if (btn_pause) w_state_next = ST_PAUSE;
            w_sec_inc = tick_1hz;
            w_min_inc = w_sec_carry;
          end
        end
        ST_PAUSE: begin
          if (adj_en)         w_state_next = ST_ADJUST;
          else if (btn_pause) w_state_next = ST_RUN;
        end
        ST_ADJUST: begin
          if (!adj_en) begin
            w_state_next = ST_PAUSE;
            w_phase_next = 1'b0;
          end else if (tick_2hz) begin
            // Seconds carry is deliberately not forwarded to minutes here
            w_adj_tick   = 1'b1;
            w_phase_next = ~r_phase;
            w_sec_inc    = adj_sel;
            w_min_inc    = ~adj_sel;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end

    // adj_sel is only sampled on a blink tick; between ticks the mask holds
    if ((w_state_next == ST_ADJUST) && w_phase_next) begin
      if (w_adj_tick) w_blank_next = adj_sel ? c_BLANK_SEC : c_BLANK_MIN;
      else            w_blank_next = r_blank;
    end
  end

  // State, blink phase and blank mask registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= 1'b0;
      r_blank <= 4'b0000;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_blank <= w_blank_next;
    end
  end

  assign state = r_state;
  assign blank = r_blank;

  // Minutes wrap carry has no consumer
  logic w_unused_carry;
  assign w_unused_carry = w_min_carry;

`ifdef STOPWATCH_LAP_EN
  logic r_hold, w_hold_next;
  logic [4*c_BCD_W-1:0] r_lap;

  // Hold releases on reset, pause, entry to ADJUST or a second lap press;
  // a lap press is honoured only in RUN
  always_comb begin
    w_hold_next = r_hold;
    if (btn_reset || btn_pause ||
        ((w_state_next == ST_ADJUST) && (r_state != ST_ADJUST)))
      w_hold_next = 1'b0;
    else if (btn_lap && (r_state == ST_RUN))
      w_hold_next = ~r_hold;
  end

  // Lap hold flag and frozen digits captured from the current count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= 1'b0;
      r_lap  <= '0;
    end else begin
      r_hold <= w_hold_next;
      if (w_hold_next && !r_hold)
        r_lap <= {w_min_t, w_min_o, w_sec_t, w_sec_o};
    end
  end

  assign {led_0, led_1, led_2, led_3} =
      r_hold ? r_lap : {w_min_t, w_min_o, w_sec_t, w_sec_o};
`else
  logic w_unused_lap;
  assign w_unused_lap = btn_lap;

  assign {led_0, led_1, led_2, led_3} = {w_min_t, w_min_o, w_sec_t, w_sec_o};
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_ctrl
//  Description : Directed self-checking bench for stopwatch_ctrl. Digits are
//                compared packed as 16'hMMSS.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, tick_2hz, btn_pause, btn_reset, btn_lap, adj_en, adj_sel;
  logic [3:0] led_0, led_1, led_2, led_3, blank;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  stopwatch_ctrl #(.MAX_MINUTES(59)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .tick_2hz  (tick_2hz),
    .btn_pause (btn_pause),
    .btn_reset (btn_reset),
    .btn_lap   (btn_lap),
    .adj_en    (adj_en),
    .adj_sel   (adj_sel),
    .led_0     (led_0),
    .led_1     (led_1),
    .led_2     (led_2),
    .led_3     (led_3),
    .blank     (blank),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp_v);
    end
  endtask

  function automatic logic [15:0] digits();
    return {led_0, led_1, led_2, led_3};
  endfunction

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
    end
  endtask

  task automatic tick2(input int n);
    for (int i = 0; i < n; i++) begin
      tick_2hz = 1'b1; step(); tick_2hz = 1'b0;
    end
  endtask

  task automatic press_pause();
    btn_pause = 1'b1; step(); btn_pause = 1'b0;
  endtask

  task automatic press_reset();
    btn_reset = 1'b1; step(); btn_reset = 1'b0;
  endtask

  task automatic press_lap();
    btn_lap = 1'b1; step(); btn_lap = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {tick_1hz, tick_2hz, btn_pause, btn_reset, btn_lap, adj_en, adj_sel} = '0;
    #23;
    check("rst_digits", digits(), 16'h0000);
    check("rst_blank",  {12'h0, blank}, 16'h0000);
    check("rst_state",  {14'h0, state}, 16'd0);
    rst_n = 1'b1;
    step();

    // Count 61 seconds from zero: carry into minutes
    press_pause();
    check("idle_to_run", {14'h0, state}, 16'd1);
    tick1(61);
    check("run_61s", digits(), 16'h0101);
    check("run_61s_state", {14'h0, state}, 16'd1);

    // Preload 59:59 via ADJUST, then roll over in RUN
    press_reset();
    check("reset_idle", {14'h0, state}, 16'd0);
    adj_en = 1'b1; step();
    check("enter_adjust", {14'h0, state}, 16'd3);
    adj_sel = 1'b0; tick2(59);
    check("adj_min59", digits(), 16'h5900);
    check("adj_min59_blank", {12'h0, blank}, 16'h0003);
    adj_sel = 1'b1; tick2(59);
    check("adj_5959", digits(), 16'h5959);
    check("adj_5959_blank", {12'h0, blank}, 16'h0000);
    adj_en = 1'b0; step();
    check("adj_exit_pause", {14'h0, state}, 16'd2);
    press_pause();
    tick1(1);
    check("wrap_0000", digits(), 16'h0000);
    check("wrap_state_run", {14'h0, state}, 16'd1);

    // Pause coinciding with a tick: the tick counts
    tick1(5);
    check("run_0005", digits(), 16'h0005);
    btn_pause = 1'b1; tick_1hz = 1'b1; step();
    btn_pause = 1'b0; tick_1hz = 1'b0;
    check("pause_tick_cnt", digits(), 16'h0006);
    check("pause_tick_state", {14'h0, state}, 16'd2);
    tick1(3);
    check("pause_hold", digits(), 16'h0006);

    // Adjust seconds past 59 without minute carry, blink on each tick
    adj_en = 1'b1; adj_sel = 1'b1; step();
    tick2(52);
    check("adj_0058", digits(), 16'h0058);
    btn_pause = 1'b1; tick_1hz = 1'b1; step();
    btn_pause = 1'b0; tick_1hz = 1'b0;
    check("adj_ignore_btn", digits(), 16'h0058);
    check("adj_ignore_state", {14'h0, state}, 16'd3);
    tick2(1); check("adj_s59",   digits(), 16'h0059); check("adj_s59_blank",   {12'h0, blank}, 16'h000C);
    tick2(1); check("adj_s00",   digits(), 16'h0000); check("adj_s00_blank",   {12'h0, blank}, 16'h0000);
    tick2(1); check("adj_s01",   digits(), 16'h0001); check("adj_s01_blank",   {12'h0, blank}, 16'h000C);
    step();   check("blank_held", {12'h0, blank}, 16'h000C);
    tick2(1); check("adj_s02",   digits(), 16'h0002); check("adj_s02_blank",   {12'h0, blank}, 16'h0000);
    adj_sel = 1'b0;
    tick2(1); check("adj_m01",   digits(), 16'h0102); check("adj_m01_blank",   {12'h0, blank}, 16'h0003);
    adj_en = 1'b0; step();
    check("adj_leave_blank", {12'h0, blank}, 16'h0000);
    check("adj_leave_state", {14'h0, state}, 16'd2);

    // Build 12:34, run, then btn_reset
    press_reset();
    adj_en = 1'b1; step();
    adj_sel = 1'b0; tick2(12);
    adj_sel = 1'b1; tick2(34);
    adj_en = 1'b0; step();
    press_pause();
    check("run_1234", digits(), 16'h1234);
    check("run_1234_state", {14'h0, state}, 16'd1);
    press_reset();
    check("btnrst_digits", digits(), 16'h0000);
    check("btnrst_idle", {14'h0, state}, 16'd0);
    press_pause();
    tick1(2);
    adj_en = 1'b1; press_reset();
    check("btnrst_adj_digits", digits(), 16'h0000);
    check("btnrst_adj_state", {14'h0, state}, 16'd3);
    adj_en = 1'b0; step();
    press_pause();
    tick1(3);
    check("run_0003", digits(), 16'h0003);

    // Asynchronous reset mid-cycle
    rst_n = 1'b0;
    #1;
    check("async_digits", digits(), 16'h0000);
    check("async_state", {14'h0, state}, 16'd0);
    step();
    rst_n = 1'b1;
    step();

    // Lap hold
    press_pause();
    tick1(10);
    check("lap_pre", digits(), 16'h0010);
    press_lap();
    tick1(5);
`ifdef STOPWATCH_LAP_EN
    check("lap_hold", digits(), 16'h0010);
`else
    check("lap_ignored", digits(), 16'h0015);
`endif
    press_lap();
    check("lap_release", digits(), 16'h0015);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
